instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage of the RISC_V_Microprocessor pipeline. It owns the program counter, drives the combinational instruction memory's word address, and registers the returned instruction together with its PC into the IF/ID pipeline register. Handoff to decode uses a valid/ready handshake. A redirect from execute (branch/jump) or trap logic flushes the stage.

## Interface
Parameters:
- ADDRESS_SIZE, 32, PC and memory address width.
- INSTRUCTION_SIZE, 32, instruction width.
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_address  output  ADDRESS_SIZE  byte address to instruction memory, always equal to current PC.
- imem_instruction  input  INSTRUCTION_SIZE  combinational read data for imem_address.
- redirect_valid  input  1  replace the PC with redirect_pc and flush.
- redirect_pc  input  ADDRESS_SIZE  redirect target.
- if_valid  output  1  IF/ID register holds a live instruction.
- if_ready  input  1  decode accepts the IF/ID contents this cycle.
- if_pc  output  ADDRESS_SIZE  PC of the instruction in IF/ID.
- if_instruction  output  INSTRUCTION_SIZE  instruction in IF/ID.
- misaligned_fault  output  1  present only with IF_MISALIGN_CHECK_EN (see Configuration).

## Operation
- State machine (fetch_state_t):
  - RUN: normal fetch.
  - FAULT: fetch halted; exists only with the macro.
  - Reset state is RUN.
- Reset values:
  - pc = RESET_PC, so imem_address = RESET_PC.
  - if_valid = 0.
  - if_pc = 0.
  - if_instruction = 32'h0000_0013 (NOP).
  - misaligned_fault = 0.
- Advance condition: advance = !if_valid || if_ready.
- In RUN, when advance is true and there is no redirect:
  - IF/ID loads {pc, imem_instruction} and sets if_valid = 1.
  - pc <= pc + 4.
- Stall: when if_valid && !if_ready, pc, if_pc, if_instruction and if_valid all hold. imem_address stays stable.
- Redirect has priority over stall and advance:
  - pc <= redirect_pc.
  - if_valid <= 0; the held instruction is discarded even if if_ready was low.
- Simultaneous redirect_valid and if_ready: decode consumes the current IF/ID contents. The next-cycle flush still applies and no sequential instruction is captured.
- PC arithmetic: unsigned ADDRESS_SIZE, wraps from 32'hFFFF_FFFC to 32'h0000_0000 with no flag.
- Reset mid-operation clears IF/ID and the PC asynchronously. There is no partial-state recovery.

## Timing
- Fetch latency: PC presented in cycle N appears on if_instruction/if_pc with if_valid = 1 in cycle N+1.
- Throughput: 1 instruction per cycle while if_ready stays high.
- Redirect asserted in cycle N:
  - Cycle N+1: pc = target and if_valid = 0.
  - Cycle N+2: target instruction valid.
  - Branch penalty is 1 bubble beyond the flushed slot.
- First valid instruction after reset release: the first clk edge after rst_n rises.
- All outputs are registered except imem_address, which is the PC register output.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with redirect_pc[1:0] != 0 sets misaligned_fault = 1 and enters FAULT.
  - In FAULT, if_valid stays 0 and the PC holds the faulting target.
  - An aligned redirect clears the fault and returns to RUN, with the same timing as a normal redirect.
  - A further misaligned redirect keeps FAULT.
- IF_MISALIGN_CHECK_EN undefined:
  - The misaligned_fault port and the FAULT state are absent.
  - redirect_pc[1:0] is forced to 2'b00 when loaded into the PC.

## Structure
- riscv_pkg holds:
  - fetch_state_t enum.
  - PC_INCREMENT = 4.
  - NOP_INSTRUCTION = 32'h0000_0013.
  - Default RESET_PC constant.
- One sub-module, fetch_pc_gen, computes the next-PC mux (redirect / increment / hold) and contains the PC register.
- instruction_fetch holds the IF/ID register and the state machine.
- Instruction_Memory is instantiated beside this block at top level, not inside it.

## Test plan
- Reset and streaming:
  - Stimulus: reset, then release with memory words 0x00100093, 0x00200113, 0x00114463 at 0x0/0x4/0x8, if_ready = 1.
  - Required: if_pc = 0, 4, 8 on consecutive cycles, each with the matching instruction and if_valid = 1.
  - Required while rst_n is low: if_valid = 0 and imem_address = RESET_PC.
- Stall:
  - Stimulus: drop if_ready for 3 cycles while if_pc = 4.
  - Required: if_pc = 4, if_instruction = 0x00200113 and imem_address = 8 all hold, then streaming resumes with if_pc = 8.
- Redirect:
  - Stimulus: redirect_valid with redirect_pc = 0x14 in cycle N.
  - Required: if_valid = 0 in N+1; if_pc = 0x14 with if_valid = 1 in N+2.
- Redirect during stall:
  - Stimulus: if_ready = 0 and redirect_pc = 0x10 in the same cycle.
  - Required: the held instruction is dropped and the 0x10 instruction is valid 2 cycles later.
- PC wrap:
  - Stimulus: RESET_PC = 32'hFFFF_FFFC.
  - Required: if_pc = 32'hFFFF_FFFC, then 32'h0000_0000.
- Misalignment, with the macro defined:
  - Stimulus: redirect_pc = 0x6.
  - Required: misaligned_fault = 1 and if_valid stays 0.
  - Stimulus: then redirect_pc = 0x8.
  - Required: the fault clears and the 0x8 instruction is valid 2 cycles later.
  - Without the macro, redirect_pc = 0x6 yields if_pc = 0x4.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V fetch stage.
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   defined   : fetch_state_t carries a FAULT state for misaligned redirects.
//   undefined : fetch_state_t has only the RUN state.
package riscv_pkg;

  localparam int unsigned PC_INCREMENT     = 4;
  localparam logic [31:0] NOP_INSTRUCTION  = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef IF_MISALIGN_CHECK_EN
  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFault = 1'b1
  } fetch_state_t;
`else
  typedef enum logic [0:0] {
    StRun = 1'b0
  } fetch_state_t;
`endif

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC selection for the fetch stage.
//
// Ports:
//   clk             : system clock
//   rst_n           : asynchronous active-low reset, loads RESET_PC
//   redirect_en     : load redirect_target (highest priority)
//   redirect_target : new PC on a redirect
//   increment_en    : advance PC by PC_INCREMENT
//   pc              : current PC (registered)
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned             ADDRESS_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC     = DEFAULT_RESET_PC[ADDRESS_SIZE-1:0]
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    redirect_en,
  input  logic [ADDRESS_SIZE-1:0] redirect_target,
  input  logic                    increment_en,
  output logic [ADDRESS_SIZE-1:0] pc
);

  logic [ADDRESS_SIZE-1:0] pc_d;
  logic [ADDRESS_SIZE-1:0] pc_q;

  // Unsigned add wraps silently at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (redirect_en) begin
      pc_d = redirect_target;
    end else if (increment_en) begin
      pc_d = pc_q + ADDRESS_SIZE'(PC_INCREMENT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// registers {pc, instruction} into the IF/ID register with a valid/ready handoff.
// A redirect replaces the PC and flushes IF/ID.
//
// Optional feature macro: IF_MISALIGN_CHECK_EN
//   defined   : misaligned redirect targets raise misaligned_fault and halt fetch
//               until an aligned redirect arrives.
//   undefined : redirect_pc[1:0] is forced to zero and misaligned_fault is absent.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_address      : byte address to instruction memory (the PC register)
//   imem_instruction  : combinational read data for imem_address
//   redirect_valid    : replace PC with redirect_pc and flush
//   redirect_pc       : redirect target
//   if_valid          : IF/ID holds a live instruction
//   if_ready          : decode accepts IF/ID this cycle
//   if_pc             : PC of the IF/ID instruction
//   if_instruction    : IF/ID instruction
//   misaligned_fault  : misaligned redirect seen (macro builds only)
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int unsigned             ADDRESS_SIZE     = 32,
  parameter int unsigned             INSTRUCTION_SIZE = 32,
  parameter logic [ADDRESS_SIZE-1:0] RESET_PC         = DEFAULT_RESET_PC[ADDRESS_SIZE-1:0]
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [ADDRESS_SIZE-1:0]     imem_address,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  input  logic                        redirect_valid,
  input  logic [ADDRESS_SIZE-1:0]     redirect_pc,
  output logic                        if_valid,
  input  logic                        if_ready,
  output logic [ADDRESS_SIZE-1:0]     if_pc,
  output logic [INSTRUCTION_SIZE-1:0] if_instruction
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                        misaligned_fault
`endif
);

  fetch_state_t            state_q;
  logic                    advance;
  logic                    capture;
  logic [ADDRESS_SIZE-1:0] pc;
  logic [ADDRESS_SIZE-1:0] redirect_target;

  assign advance = !if_valid || if_ready;
  // Redirect wins; a redirect cycle never captures the sequential instruction.
  assign capture = !redirect_valid && advance && (state_q == StRun);

`ifdef IF_MISALIGN_CHECK_EN
  logic redirect_misaligned;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
  // Keep the faulting target in the PC so it is visible on imem_address.
  assign redirect_target     = redirect_pc;
`else
  assign redirect_target     = redirect_pc & ~ADDRESS_SIZE'(3);
`endif

  fetch_pc_gen #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .RESET_PC     (RESET_PC)
  ) u_fetch_pc_gen (
    .clk             (clk),
    .rst_n           (rst_n),
    .redirect_en     (redirect_valid),
    .redirect_target (redirect_target),
    .increment_en    (capture),
    .pc              (pc)
  );

  assign imem_address = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StRun;
      if_valid       <= 1'b0;
      if_pc          <= '0;
      if_instruction <= INSTRUCTION_SIZE'(NOP_INSTRUCTION);
`ifdef IF_MISALIGN_CHECK_EN
      misaligned_fault <= 1'b0;
`endif
    end else if (redirect_valid) begin
      if_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
      state_q          <= redirect_misaligned ? StFault : StRun;
      misaligned_fault <= redirect_misaligned;
`else
      state_q          <= StRun;
`endif
    end else if (capture) begin
      if_valid       <= 1'b1;
      if_pc          <= pc;
      if_instruction <= imem_instruction;
    end
  end

endmodule
